// File: rtl/window_fetcher_if.sv
// Bus bundle for window_fetcher: start/base request, memory read port and
// window output handshake. master = fetcher side, slave = environment side.
interface window_fetcher_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int K          = 5
);
  logic                         start;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic                         mem_en;
  logic                         mem_rw;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_rdata;
  logic [K*K*DATA_WIDTH-1:0]    win_data;
  logic                         win_valid;
  logic                         win_ready;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, base_addr, mem_rdata, win_ready,
    output mem_en, mem_rw, mem_addr, win_data, win_valid, busy, done
  );

  modport slave (
    output start, base_addr, mem_rdata, win_ready,
    input  mem_en, mem_rw, mem_addr, win_data, win_valid, busy, done
  );
endinterface

// File: rtl/window_fetcher.sv
// Fetches a KxK window of words from a row-strided feature map and presents it
// packed with a valid/ready handshake. Optional win_count via WINDOW_FETCHER_COUNT_EN.
module window_fetcher #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int K          = 5,
  parameter int MAP_WIDTH  = 28
) (
  input  logic                clk,
  input  logic                rst,
  window_fetcher_if.master    bus
`ifdef WINDOW_FETCHER_COUNT_EN
  ,
  output logic [15:0]         win_count
`endif
);

  localparam int unsigned N  = K * K;
  localparam int          CW = $clog2(K + 1);
  localparam int          IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD
  } state_t;

  state_t                   state;
  state_t                   state_next;

  logic [ADDR_WIDTH-1:0]    row_base;
  logic [CW-1:0]            row;
  logic [CW-1:0]            col;
  logic [IW-1:0]            idx;
  logic [IW-1:0]            cap_idx;
  logic                     cap_valid;
  logic [N*DATA_WIDTH-1:0]  win_data;
  logic                     done_r;
  logic                     last_col;
  logic                     last_row;
  logic                     handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    last_col      = (col == CW'(K - 1));
    last_row      = (row == CW'(K - 1));
    handshake     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.win_valid = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = done_r;
    bus.win_data  = win_data;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        bus.mem_en   = 1'b1;
        bus.mem_rw   = 1'b1;
        // row_base carries base + row*MAP_WIDTH, so no multiplier is needed
        bus.mem_addr = row_base + ADDR_WIDTH'(col);
        if (last_col && last_row) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = HOLD;
      end
      HOLD: begin
        bus.win_valid = 1'b1;
        if (bus.win_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read data returns one cycle after the request, so capture trails the
  // request counter by one cycle; DRAIN absorbs the final word.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base  <= '0;
      row       <= '0;
      col       <= '0;
      idx       <= '0;
      cap_idx   <= '0;
      cap_valid <= 1'b0;
      win_data  <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r    <= handshake;
      cap_valid <= (state == FETCH);
      cap_idx   <= idx;

      if (cap_valid) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cap_idx == IW'(i)) begin
            win_data[i*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
          end
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            row_base <= bus.base_addr;
            row      <= '0;
            col      <= '0;
            idx      <= '0;
          end
        end
        FETCH: begin
          idx <= idx + IW'(1);
          if (last_col) begin
            col      <= '0;
            row      <= row + CW'(1);
            row_base <= row_base + ADDR_WIDTH'(MAP_WIDTH);
          end else begin
            col <= col + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef WINDOW_FETCHER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      win_count <= '0;
    end else if (handshake) begin
      win_count <= win_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_fetcher.sv
// Self-checking bench for window_fetcher: address/data scoreboard per window,
// stall, wrap, ignored start, mid-fetch reset and optional window counter.
module tb_window_fetcher;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int K  = 5;
  localparam int MW = 28;
  localparam int N  = K * K;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .K(K)) bus ();

`ifdef WINDOW_FETCHER_COUNT_EN
  logic [15:0] win_count;
`endif

  window_fetcher #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .K(K),
    .MAP_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WINDOW_FETCHER_COUNT_EN
    ,
    .win_count(win_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   mem_xor = '0;
  logic [AW-1:0]   exp_addr[$];
  logic [N*DW-1:0] exp_win[$];

  // memory model: word[a] = a ^ mem_xor, one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) bus.mem_rdata <= DW'(bus.mem_addr) ^ mem_xor;
  end

  // Runs one fetch starting from IDLE; caller is at #1 after an edge.
  task automatic run_window(input logic [AW-1:0] base, input int stall,
                            input bit pulse_start, input string tag);
    int hs;
    int reads;
    logic [AW-1:0]   a;
    logic [N*DW-1:0] w;
    logic [N*DW-1:0] cur;
    hs = 27 + stall;
    reads = 0;
    w = '0;
    cur = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        a = base + AW'(r * MW + c);
        exp_addr.push_back(a);
        w[(r*K+c)*DW +: DW] = DW'(a) ^ mem_xor;
      end
    end
    exp_win.push_back(w);
    bus.base_addr = base;
    bus.start     = 1'b1;
    bus.win_ready = (stall == 0);
    for (int cyc = 1; cyc <= hs + 2; cyc++) begin
      @(posedge clk); #1;
      bus.start     = pulse_start && (cyc == 10 || (cyc == 28 && hs > 28) || cyc == hs);
      bus.win_ready = (stall == 0) || (cyc >= hs);
      if (bus.mem_en === 1'b1) reads++;
      checks++;
      if (bus.mem_en !== (cyc <= N))
        $display("FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, bus.mem_en, (cyc <= N));
      checks++;
      if (bus.mem_rw !== (cyc <= N))
        $display("FAIL %s mem_rw cyc=%0d got=%b exp=%b", tag, cyc, bus.mem_rw, (cyc <= N));
      if (bus.mem_en !== (cyc <= N) || bus.mem_rw !== (cyc <= N)) errors++;
      if (cyc <= N) begin
        a = exp_addr.pop_front();
        checks++;
        if (bus.mem_addr !== a) begin
          errors++;
          $display("FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, bus.mem_addr, a);
        end
      end else begin
        checks++;
        if (bus.mem_addr !== '0) begin
          errors++;
          $display("FAIL %s mem_addr_idle cyc=%0d got=%h exp=0", tag, cyc, bus.mem_addr);
        end
      end
      checks++;
      if (bus.busy !== (cyc <= hs)) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, bus.busy, (cyc <= hs));
      end
      checks++;
      if (bus.win_valid !== (cyc >= 27 && cyc <= hs)) begin
        errors++;
        $display("FAIL %s win_valid cyc=%0d got=%b exp=%b", tag, cyc, bus.win_valid,
                 (cyc >= 27 && cyc <= hs));
      end
      checks++;
      if (bus.done !== (cyc == hs + 1)) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, bus.done, (cyc == hs + 1));
      end
      if (cyc == 27) cur = exp_win.pop_front();
      if (cyc >= 27) begin
        checks++;
        if (bus.win_data !== cur) begin
          errors++;
          $display("FAIL %s win_data cyc=%0d got=%h exp=%h", tag, cyc, bus.win_data, cur);
        end
      end
    end
    bus.start     = 1'b0;
    bus.win_ready = 1'b0;
    checks++;
    if (reads != N) begin
      errors++;
      $display("FAIL %s read_count got=%0d exp=%0d", tag, reads, N);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_rw !== 1'b0 || bus.mem_addr !== '0 ||
        bus.win_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.win_data !== '0) begin
      errors++;
      $display("FAIL %s outputs en=%b rw=%b addr=%h valid=%b busy=%b done=%b data=%h exp all 0",
               tag, bus.mem_en, bus.mem_rw, bus.mem_addr, bus.win_valid, bus.busy,
               bus.done, bus.win_data);
    end
  endtask

  task automatic check_elem(input int r, input int c, input logic [DW-1:0] exp,
                            input string tag);
    logic [N*DW-1:0] d;
    logic [DW-1:0]   e;
    d = bus.win_data;
    e = d[(r*K+c)*DW +: DW];
    checks++;
    if (e !== exp) begin
      errors++;
      $display("FAIL %s elem(%0d,%0d) got=%h exp=%h", tag, r, c, e, exp);
    end
  endtask

  task automatic test_reset();
    bus.start     = 1'b1;
    bus.win_ready = 1'b1;
    bus.base_addr = 16'h1234;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    bus.start = 1'b0;
    bus.win_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    mem_xor = '0;
    run_window(16'h0000, 0, 1'b0, "basic");
    check_elem(0, 0, 16'h0000, "basic");
    check_elem(0, 4, 16'h0004, "basic");
    check_elem(1, 0, 16'd28, "basic");
    check_elem(4, 4, 16'd116, "basic");
  endtask

  task automatic test_stall();
    mem_xor = 16'h5A3C;
    run_window(16'h0123, 10, 1'b0, "stall");
  endtask

  task automatic test_wrap();
    mem_xor = '0;
    run_window(16'hFFF0, 0, 1'b0, "wrap");
    check_elem(0, 0, 16'hFFF0, "wrap");
    check_elem(1, 0, 16'h000C, "wrap");
  endtask

  task automatic test_start_ignored();
    mem_xor = 16'h0F0F;
    run_window(16'h0200, 5, 1'b1, "start_ign");
  endtask

  task automatic test_reset_mid_fetch();
    logic [AW-1:0] a;
    mem_xor = 16'h3C3C;
    for (int i = 0; i < N; i++) exp_addr.push_back(16'h0400 + AW'((i / K) * MW + (i % K)));
    bus.base_addr = 16'h0400;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      a = exp_addr.pop_front();
      checks++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== a) begin
        errors++;
        $display("FAIL rst_mid fetch cyc=%0d en=%b addr=%h exp en=1 addr=%h",
                 cyc, bus.mem_en, bus.mem_addr, a);
      end
    end
    exp_addr.delete();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.win_ready = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("rst_mid");
    rst = 1'b0;
    bus.start = 1'b0;
    bus.win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid after i=%0d done=%b busy=%b exp 0 0", i, bus.done, bus.busy);
      end
    end
    run_window(16'h0400, 0, 1'b0, "rst_refetch");
  endtask

`ifdef WINDOW_FETCHER_COUNT_EN
  task automatic test_back_to_back();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (win_count !== 16'd0) begin
      errors++;
      $display("FAIL count_reset got=%0d exp=0", win_count);
    end
    mem_xor = 16'h1111;
    for (int i = 0; i < 3; i++) run_window(16'h0010 + AW'(i), 0, 1'b0, "b2b");
    checks++;
    if (win_count !== 16'd3) begin
      errors++;
      $display("FAIL count_b2b got=%0d exp=3", win_count);
    end
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.win_ready = 1'b0;
    bus.base_addr = '0;
    bus.mem_rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_start_ignored();
    test_reset_mid_fetch();
`ifdef WINDOW_FETCHER_COUNT_EN
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_fetcher.md
WINDOW_FETCHER -- requirements
Module: window_fetcher

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 16 and set the memory address width.
REQ-002 The parameter DATA_WIDTH SHALL default to 16 and set the signed feature-word width.
REQ-003 The parameter K SHALL default to 5 and set the square window edge, giving K*K words per window.
REQ-004 The parameter MAP_WIDTH SHALL default to 28 and set the row stride, in words, of the feature map in memory.
REQ-005 The port clk SHALL be an input of width 1 carrying the single clock; all logic is on its rising edge.
REQ-006 The port rst SHALL be an input of width 1 carrying the reset, which is synchronous and active-high.
REQ-007 The port start SHALL be an input of width 1 that requests one window fetch.
REQ-008 The port base_addr SHALL be an input of width ADDR_WIDTH giving the word address of window element (0,0).
REQ-009 The port mem_en SHALL be an output of width 1 giving the memory access enable.
REQ-010 The port mem_rw SHALL be an output of width 1 with 1 meaning read; this block never writes.
REQ-011 The port mem_addr SHALL be an output of width ADDR_WIDTH giving the memory word address.
REQ-012 The port mem_rdata SHALL be an input of width DATA_WIDTH carrying read data, valid one cycle after mem_en.
REQ-013 The port win_data SHALL be an output of width K*K*DATA_WIDTH carrying the packed window.
REQ-014 The port win_valid SHALL be an output of width 1 indicating that win_data holds a complete window.
REQ-015 The port win_ready SHALL be an input of width 1 indicating that the downstream PE accepts the window.
REQ-016 The port busy SHALL be an output of width 1, high whenever state is not IDLE.
REQ-017 The port done SHALL be an output of width 1 that pulses high for one cycle after a window transfer.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DRAIN and HOLD.
REQ-019 In IDLE, start=1 SHALL latch base_addr, clear the row and column counters, and enter FETCH on the next edge.
REQ-020 start SHALL be ignored in every state other than IDLE, including the cycle in which a HOLD handshake completes.
REQ-021 In FETCH, each cycle SHALL drive mem_en=1, mem_rw=1 and mem_addr=(base+r*MAP_WIDTH+c) mod 2^ADDR_WIDTH, with c advancing 0..K-1 and then r incrementing.
REQ-022 FETCH SHALL last exactly K*K cycles and then go to DRAIN.
REQ-023 Outside FETCH, mem_en SHALL be 0, mem_rw 0 and mem_addr 0.
REQ-024 The mem_rdata sampled one cycle after the request for (r,c) SHALL be stored in win_data[(r*K+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-025 DRAIN SHALL last one cycle, capturing the last word, and then go to HOLD.
REQ-026 With K=5, win_valid SHALL first be high in cycle 27 when start is sampled in cycle 0.
REQ-027 In HOLD, win_valid=1 and win_data SHALL hold stable until win_valid&&win_ready.
REQ-028 On that handshake the FSM SHALL go to IDLE and done SHALL be 1 in the following cycle only.
REQ-029 win_ready SHALL be ignored outside HOLD.
REQ-030 win_data SHALL retain the last window after the handshake until overwritten by the next fetch.
REQ-031 Address arithmetic SHALL be unsigned and wrap modulo 2^ADDR_WIDTH; data SHALL pass through unmodified.

Reset
REQ-032 When rst=1 at a clock edge, state SHALL become IDLE and mem_en, mem_rw, mem_addr, win_valid, busy, done and all of win_data SHALL become 0.
REQ-033 Reset asserted mid-FETCH or mid-HOLD SHALL discard the partial window with no done pulse.
REQ-034 rst SHALL take priority over start and win_ready.

Configuration
REQ-035 When macro WINDOW_FETCHER_COUNT_EN is defined, an output win_count of width 16 SHALL exist, reset to 0, incrementing by 1 on each completed handshake and wrapping from 0xFFFF to 0.
REQ-036 When WINDOW_FETCHER_COUNT_EN is undefined, neither the win_count port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-037 A bench SHALL cover: memory word[a]=a, base_addr=0, start in cycle 0, win_ready=1 -> mem_addr sequence 0,1,2,3,4,28,...,116 in cycles 1..25, win_valid in cycle 27, element(4,4)=116, done in cycle 28.
REQ-038 A bench SHALL cover: win_ready held 0 for 10 cycles -> win_valid and win_data stable, then a single handshake and a single done pulse.
REQ-039 A bench SHALL cover: base_addr=0xFFF0 -> element(0,0) at address 0xFFF0 and element(1,0) at address 0x000C (wrap).
REQ-040 A bench SHALL cover: start pulsed during FETCH and HOLD -> no restart and exactly 25 reads per window.
REQ-041 A bench SHALL cover: rst in cycle 12 of FETCH -> all outputs 0 next cycle, no done, and a new start fetches cleanly.
REQ-042 A bench SHALL cover, with WINDOW_FETCHER_COUNT_EN defined: 3 back-to-back windows -> win_count=3.
